uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `UART_TX` instance among `NUM_REQ` byte sources. Each requester gets a one-byte holding register behind a valid/ready handshake. A sequencing FSM launches one byte at a time into the transmitter, waits for its done pulse, and enforces an inter-byte guard gap. A watchdog recovers the arbiter if the done pulse is never seen. The block sits between the command/debug byte producers and `UART_TX`; its outputs drive `i_TX_DV`/`i_TX_Byte` directly.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `CLKS_PER_BIT`, 217: must match the `UART_TX` instance (25 MHz / 115200)
- `GAP_CLKS`, 0: idle clocks inserted after each byte's done pulse
- `TIMEOUT_CLKS`, 12*`CLKS_PER_BIT`: maximum clocks from launch to `i_TX_Done`
- `i_Clock`  in  1  system clock
- `i_Rst_L`  in  1  asynchronous active-low reset
- `i_Req_DV`  in  NUM_REQ  per-requester byte valid
- `i_Req_Byte`  in  8*NUM_REQ  packed bytes; requester k in bits [8k+7:8k]
- `o_Req_Ready`  out  NUM_REQ  holding register k empty
- `o_Req_Sent`  out  NUM_REQ  one-clock pulse when requester k's byte completes
- `o_TX_DV`  out  1  to `UART_TX.i_TX_DV`; one-clock launch pulse
- `o_TX_Byte`  out  8  to `UART_TX.i_TX_Byte`
- `i_TX_Done`  in  1  from `UART_TX.o_TX_Done`
- `o_Grant_Id`  out  clog2(NUM_REQ)  requester currently owning the transmitter
- `o_Busy`  out  1  FSM not in IDLE
- `o_Timeout_Err`  out  1  one-clock pulse on watchdog abort

## Operation
- Holding register k:
  - Accept when `i_Req_DV[k] & o_Req_Ready[k]`. Capture the byte and set `pending[k]`.
  - `o_Req_Ready[k] = ~pending[k]`.
  - `i_Req_DV` while not ready is ignored. There is no overwrite.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE: if any `pending`, pick the first pending index at or after `rr_ptr`, wrapping modulo NUM_REQ. Register the pick into `o_Grant_Id` and the byte into `o_TX_Byte`, then go to LAUNCH. Otherwise stay in IDLE. `i_TX_Done` is ignored in IDLE.
- LAUNCH (exactly one cycle):
  - Assert `o_TX_DV=1`.
  - Clear `pending[grant]` and set `rr_ptr=grant+1` (wraps to 0).
  - Clear the watchdog counter and go to WAIT_DONE.
- WAIT_DONE:
  - Count clocks.
  - On `i_TX_Done`: pulse `o_Req_Sent[grant]`. Go to GAP if `GAP_CLKS>0`, otherwise to IDLE.
  - If the count reaches `TIMEOUT_CLKS-1` without done: pulse `o_Timeout_Err`, go to IDLE, no `o_Req_Sent`. The byte is dropped.
- GAP: count `GAP_CLKS` clocks, then go to IDLE.
- `o_TX_Byte` holds its value from LAUNCH until the next grant.

## Timing
- Reset values: state IDLE, `pending=0`, `rr_ptr=0`, `o_Req_Ready` all 1, `o_Req_Sent=0`, `o_TX_DV=0`, `o_TX_Byte=0`, `o_Grant_Id=0`, `o_Busy=0`, `o_Timeout_Err=0`.
- Accept at edge t → `pending` high from t → `o_TX_DV` high during cycle t+2, when the FSM is idle.
- `o_Req_Ready[k]` returns high in the cycle after LAUNCH. The requester may present its next byte then. That byte is arbitrated behind all other pending requesters.
- Back-to-back throughput: one byte per (UART frame + `GAP_CLKS` + 2) clocks.
- Simultaneous DV on several requesters in one cycle: all are accepted. Grants are issued in round-robin order from `rr_ptr`.
- A new accept on requester k in the same cycle that k is being granted is impossible, because ready=0 while pending.
- Counter widths: `clog2(TIMEOUT_CLKS)` and `clog2(GAP_CLKS+1)`. A counter equal to the limit terminates. No wrap.
- Reset mid-byte:
  - All state clears immediately (asynchronous).
  - `UART_TX` has no reset and may finish the frame. Its stray `i_TX_Done` arrives while the arbiter is in IDLE and is ignored.
  - Software must allow one frame time before relying on the line.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding, a 2-bit enum.
  - Default `CLKS_PER_BIT`, a `UART_FRAME_BITS=10` constant, and the default timeout expression.
- Sub-module `rr_arbiter`:
  - Combinational pick from (`pending`, `rr_ptr`) to (`grant_valid`, `grant_id`).
  - Reusable for the planned RX-side dispatcher.

## Test plan
Test-bench shape: `UART_TX` and `UART_RX` with `CLKS_PER_BIT=217`, and the line idles high when TX is not active.
- **Single byte.** Requester 2 sends 0x3F.
  - `o_TX_DV` pulses 2 clocks after the accept.
  - `UART_RX` yields 0x3F.
  - `o_Req_Sent[2]` pulses once; `o_Req_Ready[2]` is high again.
- **Simultaneous requests.** All four requesters send 0xA0..0xA3 in the same cycle.
  - Received order is 0xA0, 0xA1, 0xA2, 0xA3.
  - Requester 0 then re-sends 0x55 after its ready rises: 0x55 follows 0xA3.
- **Fairness.** Requester 1 streams continuously while requester 3 sends once.
  - Requester 3's byte is sent within 2 frames of its accept.
- **Gap.** `GAP_CLKS=100`, two bytes queued.
  - `o_TX_DV` pulses are spaced exactly by frame + 102 clocks.
- **Watchdog.** Tie `i_TX_Done=0` and send 0x11.
  - `o_Timeout_Err` pulses at `TIMEOUT_CLKS` after launch.
  - No `o_Req_Sent`; the FSM returns to IDLE and serves the next request.
- **Reset mid-byte.** Deassert `i_Rst_L` during data bit 4.
  - Outputs take their reset values immediately.
  - The late `i_TX_Done` causes no `o_Req_Sent`.
  - A post-reset byte 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding and timing defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } tx_state_e;

  localparam int DEF_CLKS_PER_BIT = 217;  // 25 MHz / 115200
  localparam int UART_FRAME_BITS  = 10;   // start + 8 data + stop

  // Watchdog default: one full frame plus two bit times of slack.
  function automatic int def_timeout_clks(input int clks_per_bit);
    return (UART_FRAME_BITS + 2) * clks_per_bit;
  endfunction

  // Width of a counter that must hold values 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending index at or after rr_ptr,
// wrapping modulo N. Shared with the RX-side dispatcher.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   pending,
  input  logic [IDW-1:0] rr_ptr,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  // One spare bit so rr_ptr + offset never overflows before the wrap.
  logic [IDW:0] idx;

  // Scan offsets 0..N-1 from rr_ptr; the first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!grant_valid && pending[idx[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// sources: per-requester holding registers, launch/wait/gap sequencer and a
// watchdog that drops the byte if the transmitter never reports done.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter  int GAP_CLKS     = 0,
  parameter  int TIMEOUT_CLKS = def_timeout_clks(CLKS_PER_BIT),
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Req_Sent,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Done,
  output logic [IDW-1:0]       o_Grant_Id,
  output logic                 o_Busy,
  output logic                 o_Timeout_Err
);

  localparam int WDW = cnt_w(TIMEOUT_CLKS);
  localparam int GPW = cnt_w(GAP_CLKS + 1);

  tx_state_e               state, state_n;
  logic [NUM_REQ-1:0]      pending;
  logic [NUM_REQ-1:0][7:0] hold;
  logic [IDW-1:0]          rr_ptr, pick_id;
  logic                    pick_vld;
  logic [WDW-1:0]          wd_cnt;
  logic [GPW-1:0]          gap_cnt;
  logic                    take, done_ok, wd_fire;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_valid (pick_vld),
    .grant_id    (pick_id)
  );

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_hold
    // Holding register k: fill on handshake, drain when its byte launches.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        pending[k] <= 1'b0;
        hold[k]    <= '0;
      end else if (i_Req_DV[k] && !pending[k]) begin
        pending[k] <= 1'b1;
        hold[k]    <= i_Req_Byte[8*k +: 8];
      end else if (state == ST_LAUNCH && o_Grant_Id == IDW'(k)) begin
        pending[k] <= 1'b0;
      end
    end
  end

  assign o_Req_Ready = ~pending;

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Sequencer: done has priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    done_ok = 1'b0;
    wd_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          take    = 1'b1;
          state_n = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_n = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_TX_Done) begin
          done_ok = 1'b1;
          state_n = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
        end else if (wd_cnt == WDW'(TIMEOUT_CLKS - 1)) begin
          wd_fire = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GPW'(GAP_CLKS - 1)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Grant/byte capture on pick, pointer advance on launch.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Grant_Id <= '0;
      o_TX_Byte  <= '0;
      rr_ptr     <= '0;
    end else begin
      if (take) begin
        o_Grant_Id <= pick_id;
        o_TX_Byte  <= hold[pick_id];
      end
      if (state == ST_LAUNCH)
        rr_ptr <= (o_Grant_Id == IDW'(NUM_REQ - 1)) ? '0 : o_Grant_Id + IDW'(1);
    end
  end

  // Watchdog and gap counters; both stop at their terminal value.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == ST_LAUNCH)
        wd_cnt <= '0;
      else if (state == ST_WAIT_DONE && !done_ok && !wd_fire)
        wd_cnt <= wd_cnt + WDW'(1);
      if (done_ok)
        gap_cnt <= '0;
      else if (state == ST_GAP)
        gap_cnt <= gap_cnt + GPW'(1);
    end
  end

  // Launch strobe, status and completion pulses.
  always_comb begin
    o_Req_Sent = '0;
    if (done_ok) o_Req_Sent[o_Grant_Id] = 1'b1;
  end

  assign o_TX_DV       = (state == ST_LAUNCH);
  assign o_Busy        = (state != ST_IDLE);
  assign o_Timeout_Err = wd_fire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART TX/RX pair on the main
// instance, a done-only transmitter model on a GAP_CLKS=100 instance, and a
// byte scoreboard fed at stimulus time and drained by the RX model.
module tb_uart_tx_arbiter;
  localparam int NREQ  = 4;
  localparam int CPB   = 217;
  localparam int FRAME = 10 * CPB;
  localparam int TMO   = 12 * CPB;
  localparam int GAPC  = 100;
  localparam int IDLE_LIM = 8 * FRAME;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic [NREQ-1:0]   req_dv   = '0;
  logic [8*NREQ-1:0] req_byte = '0;
  logic [NREQ-1:0]   rdy, sent;
  logic              tx_dv, busy, tmo, tx_done, tx_done_raw, line;
  logic [7:0]        tx_byte;
  logic [1:0]        grant;
  logic              done_en = 1'b1;

  // gap instance
  logic [NREQ-1:0]   g_dv   = '0;
  logic [8*NREQ-1:0] g_byte = '0;
  logic [NREQ-1:0]   g_rdy, g_sent;
  logic              g_tx_dv, g_busy, g_tmo, g_done;
  logic [7:0]        g_tx_byte;
  logic [1:0]        g_grant;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .CLKS_PER_BIT(CPB), .GAP_CLKS(0), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
    .o_Req_Ready(rdy), .o_Req_Sent(sent), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
    .i_TX_Done(tx_done), .o_Grant_Id(grant), .o_Busy(busy), .o_Timeout_Err(tmo));

  uart_tx_arbiter #(.NUM_REQ(NREQ), .CLKS_PER_BIT(CPB), .GAP_CLKS(GAPC), .TIMEOUT_CLKS(TMO)) dut_gap (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(g_dv), .i_Req_Byte(g_byte),
    .o_Req_Ready(g_rdy), .o_Req_Sent(g_sent), .o_TX_DV(g_tx_dv), .o_TX_Byte(g_tx_byte),
    .i_TX_Done(g_done), .o_Grant_Id(g_grant), .o_Busy(g_busy), .o_Timeout_Err(g_tmo));

  // UART TX model (no reset): done in the last clock of the stop bit.
  logic       tx_busy  = 1'b0;
  int         tx_cnt   = 0;
  logic [9:0] tx_frame = '1;
  always @(posedge clk) begin
    if (!tx_busy) begin
      if (tx_dv) begin
        tx_busy  <= 1'b1;
        tx_cnt   <= 0;
        tx_frame <= {1'b1, tx_byte, 1'b0};
      end
    end else begin
      if (tx_cnt == FRAME - 1) tx_busy <= 1'b0;
      tx_cnt <= tx_cnt + 1;
    end
  end
  assign line        = tx_busy ? tx_frame[tx_cnt / CPB] : 1'b1;
  assign tx_done_raw = tx_busy && (tx_cnt == FRAME - 1);
  assign tx_done     = tx_done_raw & done_en;

  // Done-only transmitter model for the gap instance.
  logic g_txb = 1'b0;
  int   g_cnt = 0;
  always @(posedge clk) begin
    if (!g_txb) begin
      if (g_tx_dv) begin
        g_txb <= 1'b1;
        g_cnt <= 0;
      end
    end else begin
      if (g_cnt == FRAME - 1) g_txb <= 1'b0;
      g_cnt <= g_cnt + 1;
    end
  end
  assign g_done = g_txb && (g_cnt == FRAME - 1);

  int n_tests = 0;
  int n_fails = 0;
  logic [7:0] exp_q[$];
  int exp_sent[NREQ];
  int sent_cnt[NREQ];
  int sent3_cyc  = -1;
  int g_sent_tot = 0;
  int g_dv_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitors.
  always @(posedge clk) begin
    for (int k = 0; k < NREQ; k++) if (sent[k]) sent_cnt[k] <= sent_cnt[k] + 1;
    if (sent[3]) sent3_cyc <= cyc;
    if (g_sent != '0) g_sent_tot <= g_sent_tot + $countones(g_sent);
    if (g_tx_dv) g_dv_t.push_back(cyc);
  end

  // UART RX model: mid-bit sampling, checks each byte against the scoreboard.
  logic [7:0] rx_b;
  initial begin : rx_model
    forever begin
      @(posedge clk);
      if (line == 1'b0) begin
        repeat (CPB / 2) @(posedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(posedge clk);
          rx_b[b] = line;
        end
        repeat (CPB) @(posedge clk);
        if (exp_q.size() == 0) chk("rx_extra", 32'(rx_b), 32'h100);
        else                   chk("rx_byte", 32'(rx_b), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] b, output int acc);
    int n = 0;
    while (rdy[k] !== 1'b1 && n < IDLE_LIM) begin step(); n++; end
    chk("ready_wait", 32'(rdy[k]), 1);
    req_dv[k] = 1'b1;
    req_byte[8*k +: 8] = b;
    acc = cyc;
    step();
    req_dv[k] = 1'b0;
  endtask

  task automatic wait_dv(output int c);
    int n = 0;
    while (tx_dv !== 1'b1 && n < 50) begin step(); n++; end
    chk("dv_wait", 32'(tx_dv), 1);
    c = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(busy === 1'b0 && rdy === '1 && exp_q.size() == 0) && n < IDLE_LIM) begin
      step(); n++;
    end
    chk("idle_wait", 32'(n < IDLE_LIM), 1);
  endtask

  task automatic chk_sent();
    for (int k = 0; k < NREQ; k++) chk($sformatf("sent_cnt%0d", k), 32'(sent_cnt[k]), 32'(exp_sent[k]));
  endtask

  initial begin : guard
    #(400000 * 10);
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin : stim
    int a, l, a3, tc, n;
    // Reset values
    step(); step();
    chk("rst_ready", 32'(rdy), 32'hF);
    chk("rst_sent", 32'(sent), 0);
    chk("rst_txdv", 32'(tx_dv), 0);
    chk("rst_txbyte", 32'(tx_byte), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(tmo), 0);
    rst_n = 1'b1;
    step();

    // Single byte from requester 2
    send(2, 8'h3F, a); exp_q.push_back(8'h3F); exp_sent[2]++;
    chk("t1_dv_early", 32'(tx_dv), 0);
    step();
    chk("t1_dv", 32'(tx_dv), 1);
    chk("t1_lat", 32'(cyc - a), 2);
    chk("t1_grant", 32'(grant), 2);
    chk("t1_byte", 32'(tx_byte), 32'h3F);
    chk("t1_rdy_low", 32'(rdy[2]), 0);
    step();
    chk("t1_dv_pulse", 32'(tx_dv), 0);
    chk("t1_rdy_back", 32'(rdy[2]), 1);
    chk("t1_busy", 32'(busy), 1);
    wait_idle();
    chk_sent();

    // Fresh pointer, then all four at once
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; step();
    req_dv = 4'hF; req_byte = 32'hA3A2_A1A0;
    step();
    req_dv = '0;
    chk("t2_all_taken", 32'(rdy), 0);
    for (int k = 0; k < NREQ; k++) begin
      exp_q.push_back(8'hA0 + 8'(k));
      exp_sent[k]++;
    end
    send(0, 8'h55, a); exp_q.push_back(8'h55); exp_sent[0]++;
    wait_idle();
    chk_sent();

    // Fairness: requester 1 streams, requester 3 sends once.
    // Pointer sits past 1 after its first grant, so 3 goes before 1's next.
    send(1, 8'h10, a); exp_q.push_back(8'h10);
    send(1, 8'h11, a);
    send(3, 8'hE7, a3); exp_q.push_back(8'hE7); exp_q.push_back(8'h11);
    send(1, 8'h12, a); exp_q.push_back(8'h12);
    send(1, 8'h13, a); exp_q.push_back(8'h13);
    exp_sent[1] += 4; exp_sent[3]++;
    wait_idle();
    chk("t3_fair", 32'((sent3_cyc > a3) && (sent3_cyc - a3 <= 2 * (FRAME + 2))), 1);
    chk_sent();

    // Gap instance: two bytes queued together
    g_dv = 4'b0011; g_byte = 32'h0000_B1B0; a = cyc;
    step();
    g_dv = '0;
    n = 0;
    while (!(g_busy === 1'b0 && g_rdy === 4'hF && g_dv_t.size() >= 2) && n < IDLE_LIM) begin step(); n++; end
    chk("t4_idle_wait", 32'(n < IDLE_LIM), 1);
    chk("t4_ndv", 32'(g_dv_t.size()), 2);
    if (g_dv_t.size() >= 2) begin
      chk("t4_lat", 32'(g_dv_t[0] - a), 2);
      chk("t4_spacing", 32'(g_dv_t[1] - g_dv_t[0]), 32'(FRAME + GAPC + 2));
    end
    chk("t4_sent", 32'(g_sent_tot), 2);

    // Watchdog: done suppressed for the first byte
    done_en = 1'b0;
    send(0, 8'h11, a); exp_q.push_back(8'h11);
    wait_dv(l);
    chk("t5_lat", 32'(l - a), 2);
    send(2, 8'h22, a); exp_q.push_back(8'h22); exp_sent[2]++;
    n = 0;
    while (tmo !== 1'b1 && n < TMO + 100) begin step(); n++; end
    chk("t5_tmo_seen", 32'(tmo), 1);
    tc = cyc;
    chk("t5_tmo_time", 32'(tc - l), 32'(TMO));
    done_en = 1'b1;
    step();
    chk("t5_tmo_pulse", 32'(tmo), 0);
    chk("t5_idle", 32'(busy), 0);
    step();
    chk("t5_next_dv", 32'(tx_dv), 1);
    chk("t5_next_grant", 32'(grant), 2);
    wait_idle();
    chk_sent();

    // Reset during data bit 4; the frame still completes on the line
    send(3, 8'h5A, a); exp_q.push_back(8'h5A);
    wait_dv(l);
    while (cyc < l + 1 + 5 * CPB + 100) step();
    rst_n = 1'b0;
    #1;
    chk("t6_rdy", 32'(rdy), 32'hF);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_txdv", 32'(tx_dv), 0);
    chk("t6_byte", 32'(tx_byte), 0);
    chk("t6_grant", 32'(grant), 0);
    step(); step(); step();
    rst_n = 1'b1;
    n = 0;
    while (tx_busy && n < 2 * FRAME) begin step(); n++; end
    step(); step();
    chk_sent();
    send(1, 8'hC3, a); exp_q.push_back(8'hC3); exp_sent[1]++;
    wait_idle();
    chk_sent();

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
